// File: rtl/approx_mon_pkg.sv
// Shared types and helpers for the approximate-adder error monitor.
package approx_mon_pkg;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_REPORT = 2'd2
  } state_e;

  localparam int DRAIN_CYCLES = 2;
  localparam int DRAIN_CNT_W  = $clog2(DRAIN_CYCLES + 1);

  // Adds inc to acc and clamps the result to the all-ones value of a w-bit field.
  function automatic logic [63:0] sat_inc(input logic [63:0] acc,
                                          input logic [63:0] inc,
                                          input int unsigned w);
    logic [64:0] sum;
    logic [64:0] lim;
    sum = {1'b0, acc} + {1'b0, inc};
    lim = (65'd1 << w) - 65'd1;
    if (sum > lim) begin
      return lim[63:0];
    end
    return sum[63:0];
  endfunction

endpackage

// File: rtl/approx_err_monitor_if.sv
// Sample stream, control pulses and snapshot bus of the error monitor.
interface approx_err_monitor_if #(
  parameter int N     = 16,
  parameter int CNT_W = 32,
  parameter int ACC_W = 48
);
  logic             in_valid;
  logic             in_ready;
  logic [N-1:0]     in_x;
  logic [N-1:0]     in_y;
  logic [N-1:0]     in_s;
  logic             in_co;
  logic             clear;
  logic             report;
  logic             rpt_valid;
  logic             rpt_ready;
  logic [CNT_W-1:0] n_samples;
  logic [CNT_W-1:0] n_err;
  logic [CNT_W-1:0] n_hi_err;
  logic [ACC_W-1:0] sum_ed;
  logic [N:0]       max_ed;

  modport master (
    output in_valid, in_x, in_y, in_s, in_co, clear, report, rpt_ready,
    input  in_ready, rpt_valid, n_samples, n_err, n_hi_err, sum_ed, max_ed
  );

  modport slave (
    input  in_valid, in_x, in_y, in_s, in_co, clear, report, rpt_ready,
    output in_ready, rpt_valid, n_samples, n_err, n_hi_err, sum_ed, max_ed
  );
endinterface

// File: rtl/approx_err_stage.sv
// Stage 2: error distance, error flags and saturating statistics accumulators.
// Updates one cycle after stage 1 captures a sample; clr_i drops the in-flight sample.
module approx_err_stage
  import approx_mon_pkg::*;
#(
  parameter int N     = 16,
  parameter int K     = 7,
  parameter int CNT_W = 32,
  parameter int ACC_W = 48
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             vld_i,
  input  logic [N:0]       e_i,
  input  logic [N:0]       a_i,
  output logic [CNT_W-1:0] n_samples_o,
  output logic [CNT_W-1:0] n_err_o,
  output logic [CNT_W-1:0] n_hi_err_o,
  output logic [ACC_W-1:0] sum_ed_o,
  output logic [N:0]       max_ed_o
);
  logic [N:0]       ed;
  logic             err;
  logic             hi_err;
  logic [CNT_W-1:0] n_samples_q, n_samples_d;
  logic [CNT_W-1:0] n_err_q, n_err_d;
  logic [CNT_W-1:0] n_hi_err_q, n_hi_err_d;
  logic [ACC_W-1:0] sum_ed_q, sum_ed_d;
  logic [N:0]       max_ed_q, max_ed_d;

  always_comb begin
    ed          = (e_i >= a_i) ? (e_i - a_i) : (a_i - e_i);
    err         = (e_i != a_i);
    hi_err      = (e_i[N:K] != a_i[N:K]);
    n_samples_d = CNT_W'(sat_inc(64'(n_samples_q), 64'd1, CNT_W));
    n_err_d     = CNT_W'(sat_inc(64'(n_err_q), 64'(err), CNT_W));
    n_hi_err_d  = CNT_W'(sat_inc(64'(n_hi_err_q), 64'(hi_err), CNT_W));
    sum_ed_d    = ACC_W'(sat_inc(64'(sum_ed_q), 64'(ed), ACC_W));
    max_ed_d    = (ed > max_ed_q) ? ed : max_ed_q;
  end

  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      n_samples_q <= '0;
      n_err_q     <= '0;
      n_hi_err_q  <= '0;
      sum_ed_q    <= '0;
      max_ed_q    <= '0;
    end else if (vld_i) begin
      n_samples_q <= n_samples_d;
      n_err_q     <= n_err_d;
      n_hi_err_q  <= n_hi_err_d;
      sum_ed_q    <= sum_ed_d;
      max_ed_q    <= max_ed_d;
    end
  end

  assign n_samples_o = n_samples_q;
  assign n_err_o     = n_err_q;
  assign n_hi_err_o  = n_hi_err_q;
  assign sum_ed_o    = sum_ed_q;
  assign max_ed_o    = max_ed_q;

endmodule

// File: rtl/approx_err_monitor.sv
// Approximate-adder error monitor: one sample/cycle, stats visible 2 cycles after accept.
// report drains 2 cycles then holds a frozen snapshot until rpt_ready; in_ready is low meanwhile.
module approx_err_monitor
  import approx_mon_pkg::*;
#(
  parameter int N     = 16,
  parameter int K     = 7,
  parameter int CNT_W = 32,
  parameter int ACC_W = 48
) (
  input logic                 clk,
  input logic                 rst,
  approx_err_monitor_if.slave bus
);
  state_e                 state_q, state_d;
  logic [DRAIN_CNT_W-1:0] drain_cnt_q, drain_cnt_d;
  logic                   in_ready;
  logic                   rpt_valid;
  logic                   clr_en;
  logic                   accept;
  logic                   s1_vld_q;
  logic [N:0]             s1_e_q;
  logic [N:0]             s1_a_q;

  always_comb begin
    state_d     = state_q;
    drain_cnt_d = drain_cnt_q;
    in_ready    = 1'b0;
    rpt_valid   = 1'b0;
    clr_en      = 1'b0;
    case (state_q)
      ST_RUN: begin
        in_ready = 1'b1;
        clr_en   = bus.clear;
        if (bus.report) begin
          state_d     = ST_DRAIN;
          drain_cnt_d = '0;
        end
      end
      ST_DRAIN: begin
        if (drain_cnt_q == DRAIN_CNT_W'(DRAIN_CYCLES - 1)) begin
          state_d = ST_REPORT;
        end else begin
          drain_cnt_d = drain_cnt_q + DRAIN_CNT_W'(1);
        end
      end
      ST_REPORT: begin
        rpt_valid = 1'b1;
        if (bus.rpt_ready) begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  assign accept = bus.in_valid && in_ready;

  // Stage 1 reloads every cycle, so a clear only has to stop stage 2 from using its content.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_RUN;
      drain_cnt_q <= '0;
      s1_vld_q    <= 1'b0;
      s1_e_q      <= '0;
      s1_a_q      <= '0;
    end else begin
      state_q     <= state_d;
      drain_cnt_q <= drain_cnt_d;
      s1_vld_q    <= accept;
      if (accept) begin
        s1_e_q <= {1'b0, bus.in_x} + {1'b0, bus.in_y};
        s1_a_q <= {bus.in_co, bus.in_s};
      end
    end
  end

  approx_err_stage #(
    .N    (N),
    .K    (K),
    .CNT_W(CNT_W),
    .ACC_W(ACC_W)
  ) u_stage (
    .clk        (clk),
    .rst        (rst),
    .clr_i      (clr_en),
    .vld_i      (s1_vld_q),
    .e_i        (s1_e_q),
    .a_i        (s1_a_q),
    .n_samples_o(bus.n_samples),
    .n_err_o    (bus.n_err),
    .n_hi_err_o (bus.n_hi_err),
    .sum_ed_o   (bus.sum_ed),
    .max_ed_o   (bus.max_ed)
  );

  assign bus.in_ready  = in_ready;
  assign bus.rpt_valid = rpt_valid;

endmodule

// File: tb/tb_approx_err_monitor.sv
// Bench for approx_err_monitor: a full-width instance and a 4-bit-counter instance share stimulus.
module tb_approx_err_monitor;
  localparam int N     = 16;
  localparam int K     = 7;
  localparam int CNT_W = 32;
  localparam int CNT_S = 4;
  localparam int ACC_W = 48;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  approx_err_monitor_if #(.N(N), .CNT_W(CNT_W), .ACC_W(ACC_W)) bus ();
  approx_err_monitor_if #(.N(N), .CNT_W(CNT_S), .ACC_W(ACC_W)) bus_s ();

  approx_err_monitor #(.N(N), .K(K), .CNT_W(CNT_W), .ACC_W(ACC_W)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  approx_err_monitor #(.N(N), .K(K), .CNT_W(CNT_S), .ACC_W(ACC_W)) dut_s (
    .clk(clk), .rst(rst), .bus(bus_s)
  );

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    int     cyc;
    longint ed;
    bit     err;
    bit     hi;
  } smp_t;

  smp_t smps[$];
  int   lc      = 0;
  int   rc      = 0;
  int   k       = 0;
  bit   busy    = 1'b0;
  bit   started = 1'b0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
  endtask

  function automatic longint sat(input longint v, input int w);
    longint m;
    m = (longint'(1) << w) - 1;
    return (v > m) ? m : v;
  endfunction

  // Model: stats cover every sample accepted since the last clear/reset that has had two cycles to land.
  always @(negedge clk) begin
    longint ns, ne, nh, se, mx, e, a;
    smp_t   sm;
    k++;
    if (started) begin
      ns = 0; ne = 0; nh = 0; se = 0; mx = 0;
      foreach (smps[i]) begin
        if (smps[i].cyc >= lc && smps[i].cyc <= k - 2) begin
          ns++;
          ne += longint'(smps[i].err);
          nh += longint'(smps[i].hi);
          se += smps[i].ed;
          if (smps[i].ed > mx) mx = smps[i].ed;
        end
      end
      chk("in_ready", bus.in_ready, !busy);
      chk("rpt_valid", bus.rpt_valid, busy && (k >= rc + 3));
      chk("n_samples", bus.n_samples, sat(ns, CNT_W));
      chk("n_err", bus.n_err, sat(ne, CNT_W));
      chk("n_hi_err", bus.n_hi_err, sat(nh, CNT_W));
      chk("sum_ed", bus.sum_ed, sat(se, ACC_W));
      chk("max_ed", bus.max_ed, mx);
      chk("s.in_ready", bus_s.in_ready, !busy);
      chk("s.rpt_valid", bus_s.rpt_valid, busy && (k >= rc + 3));
      chk("s.n_samples", bus_s.n_samples, sat(ns, CNT_S));
      chk("s.n_err", bus_s.n_err, sat(ne, CNT_S));
      chk("s.n_hi_err", bus_s.n_hi_err, sat(nh, CNT_S));
      chk("s.sum_ed", bus_s.sum_ed, sat(se, ACC_W));
      chk("s.max_ed", bus_s.max_ed, mx);
    end
    if (rst) begin
      started = 1'b1;
      busy    = 1'b0;
      lc      = k + 1;
    end else begin
      if (!busy && bus.in_valid) begin
        e      = longint'(bus.in_x) + longint'(bus.in_y);
        a      = longint'(bus.in_co) * 65536 + longint'(bus.in_s);
        sm.cyc = k;
        sm.ed  = (e >= a) ? e - a : a - e;
        sm.err = (e != a);
        sm.hi  = ((e >> K) != (a >> K));
        smps.push_back(sm);
      end
      if (!busy && bus.clear) lc = k;
      if (busy && (k >= rc + 3) && bus.rpt_ready) begin
        busy = 1'b0;
      end else if (!busy && bus.report) begin
        busy = 1'b1;
        rc   = k;
      end
    end
  end

  task automatic drive(input bit v, input logic [15:0] x, input logic [15:0] y,
                       input logic [15:0] s, input bit co, input bit clr,
                       input bit rep, input bit rr);
    bus.in_valid   = v;  bus_s.in_valid  = v;
    bus.in_x       = x;  bus_s.in_x      = x;
    bus.in_y       = y;  bus_s.in_y      = y;
    bus.in_s       = s;  bus_s.in_s      = s;
    bus.in_co      = co; bus_s.in_co     = co;
    bus.clear      = clr; bus_s.clear    = clr;
    bus.report     = rep; bus_s.report   = rep;
    bus.rpt_ready  = rr; bus_s.rpt_ready = rr;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic report_and_wait();
    drive(1'b0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("drain1 rpt_valid", bus.rpt_valid, 0);
    idle(1);
    chk("drain2 rpt_valid", bus.rpt_valid, 0);
    idle(1);
    chk("report rpt_valid", bus.rpt_valid, 1);
  endtask

  task automatic ack();
    drive(1'b0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("ack in_ready", bus.in_ready, 1);
  endtask

  initial begin
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    idle(1);

    // Exact sample
    drive(1'b1, 16'h0001, 16'h0001, 16'h0002, 1'b0, 1'b0, 1'b0, 1'b0);
    report_and_wait();
    chk("t1 n_samples", bus.n_samples, 1);
    chk("t1 n_err", bus.n_err, 0);
    chk("t1 sum_ed", bus.sum_ed, 0);
    chk("t1 max_ed", bus.max_ed, 0);
    ack();

    // Single low-part error on a full-carry sum
    drive(1'b0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 16'hFFFF, 16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 1'b0, 1'b0);
    report_and_wait();
    chk("t2 n_samples", bus.n_samples, 1);
    chk("t2 n_err", bus.n_err, 1);
    chk("t2 n_hi_err", bus.n_hi_err, 0);
    chk("t2 sum_ed", bus.sum_ed, 1);
    chk("t2 max_ed", bus.max_ed, 1);
    ack();

    // High-part error, ED = 0x80
    drive(1'b0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 16'h00FF, 16'h00FF, 16'h017E, 1'b0, 1'b0, 1'b0, 1'b0);
    report_and_wait();
    chk("t3 n_err", bus.n_err, 1);
    chk("t3 n_hi_err", bus.n_hi_err, 1);
    chk("t3 max_ed", bus.max_ed, 'h80);
    chk("t3 sum_ed", bus.sum_ed, 'h80);
    ack();

    // Five back-to-back samples, EDs 0..4, report with the last
    drive(1'b0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      logic [15:0] x, y, s;
      x = 16'(3 * i);
      y = 16'(5 * i);
      s = (x + y) ^ 16'(i);
      drive(1'b1, x, y, s, 1'b0, 1'b0, (i == 4), 1'b0);
    end
    chk("t4 drain in_ready", bus.in_ready, 0);
    idle(2);
    chk("t4 rpt_valid", bus.rpt_valid, 1);
    chk("t4 n_samples", bus.n_samples, 5);
    chk("t4 n_err", bus.n_err, 4);
    chk("t4 sum_ed", bus.sum_ed, 10);
    chk("t4 max_ed", bus.max_ed, 4);
    for (int j = 0; j < 4; j++) begin
      drive(1'b1, 16'h1234, 16'h1111, 16'h0000, 1'b0, (j == 1), (j == 2), 1'b0);
      chk("t4 hold rpt_valid", bus.rpt_valid, 1);
      chk("t4 hold n_samples", bus.n_samples, 5);
      chk("t4 hold sum_ed", bus.sum_ed, 10);
    end
    ack();
    chk("t4 clear in REPORT ignored", bus.n_samples, 5);

    // Clear with a concurrent ED=3 sample drops the sample still in flight
    drive(1'b1, 16'h0100, 16'h0100, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 16'h0200, 16'h0001, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 16'h0010, 16'h0010, 16'h0023, 1'b0, 1'b1, 1'b0, 1'b0);
    report_and_wait();
    chk("t5 n_samples", bus.n_samples, 1);
    chk("t5 n_err", bus.n_err, 1);
    chk("t5 sum_ed", bus.sum_ed, 3);
    chk("t5 max_ed", bus.max_ed, 3);
    ack();

    // report and clear together keep only the concurrent sample (ED=5)
    drive(1'b1, 16'h0400, 16'h0400, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 16'h0100, 16'h0100, 16'h0205, 1'b0, 1'b1, 1'b1, 1'b0);
    idle(2);
    chk("t5b rpt_valid", bus.rpt_valid, 1);
    chk("t5b n_samples", bus.n_samples, 1);
    chk("t5b sum_ed", bus.sum_ed, 5);
    chk("t5b n_hi_err", bus.n_hi_err, 0);
    ack();

    // Saturation of the 4-bit counters, then reset inside REPORT
    drive(1'b0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 16'(i), 16'h0001, 16'(i + 2), 1'b0, 1'b0, (i == 19), 1'b0);
    end
    idle(2);
    chk("t6 n_err", bus.n_err, 20);
    chk("t6 s.n_err", bus_s.n_err, 15);
    chk("t6 s.n_samples", bus_s.n_samples, 15);
    chk("t6 s.sum_ed", bus_s.sum_ed, 20);
    chk("t6 s.rpt_valid", bus_s.rpt_valid, 1);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    chk("t6 rst rpt_valid", bus.rpt_valid, 0);
    chk("t6 rst in_ready", bus.in_ready, 1);
    chk("t6 rst n_samples", bus.n_samples, 0);
    chk("t6 rst s.n_err", bus_s.n_err, 0);
    chk("t6 rst sum_ed", bus.sum_ed, 0);
    chk("t6 rst max_ed", bus.max_ed, 0);
    idle(3);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/approx_err_monitor.md
# approx_err_monitor

Streaming error-metric monitor for the N-bit approximate adders (HOERAA and siblings). It sits on the receive side of the adder test harness. Each cycle it accepts one operand pair {X, Y} together with the adder's approximate result {Co, S}, recomputes the exact sum, and accumulates error statistics. On request it drains its pipeline and presents a stable statistics snapshot through a valid/ready handshake.

## Interface
Parameters:
- N, 16, adder operand width
- K, 7, approximate low-part width; bits [N:K] form the "upper" field
- CNT_W, 32, width of the sample and error counters
- ACC_W, 48, width of the error-distance accumulator

Ports:
- clk  in  1  single clock; all logic is on the rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  sample present
- in_ready  out  1  monitor can accept a sample
- in_x  in  N  operand X
- in_y  in  N  operand Y
- in_s  in  N  approximate sum S
- in_co  in  1  approximate carry-out Co
- clear  in  1  single-cycle pulse; zeroes the statistics
- report  in  1  single-cycle pulse; requests a snapshot
- rpt_valid  out  1  snapshot fields valid and stable
- rpt_ready  in  1  consumer accepts the snapshot
- n_samples  out  CNT_W  number of accepted samples
- n_err  out  CNT_W  samples where {Co,S} differs from the exact sum
- n_hi_err  out  CNT_W  samples where approx[N:K] differs from exact[N:K]
- sum_ed  out  ACC_W  sum of error distances
- max_ed  out  N+1  largest error distance seen

## Operation
- Exact sum: E = in_x + in_y, N+1 bits, unsigned. Approximate sum: A = {in_co, in_s}.
- Error distance: ED = |E − A|, N+1 bits, unsigned.
- Per-sample error flag: A != E. Per-sample high-part error flag: A[N:K] != E[N:K].
- FSM states:
  - RUN: in_ready = 1. A sample is accepted when in_valid && in_ready. A report pulse moves the FSM to DRAIN.
  - DRAIN: in_ready = 0. Held for exactly 2 cycles, then the FSM moves to REPORT.
  - REPORT: in_ready = 0, rpt_valid = 1, and all statistic outputs are frozen. On rpt_valid && rpt_ready the FSM returns to RUN on the next cycle.
- Counters and sum_ed saturate at all-ones and never wrap. max_ed updates when ED > max_ed.
- clear is honoured only in RUN and is ignored in DRAIN and REPORT. It zeroes all statistics and invalidates both pipeline stages. A sample accepted in the same cycle as clear is still counted.
- report and a sample accepted in the same cycle: the sample is included in the snapshot.
- report and clear in the same cycle: the clear is applied, and the snapshot contains only the concurrent sample (if any).
- report outside RUN is ignored.

## Timing
- Reset values: every statistic = 0, rpt_valid = 0, in_ready = 1, FSM = RUN, pipeline valid bits = 0.
- Reset asserted mid-DRAIN or mid-REPORT returns the block to RUN with zeroed statistics on the next edge.
- Pipeline:
  - Stage 1 registers E, A, and a valid bit.
  - Stage 2 computes ED and the flags, then updates the accumulators.
  - A sample accepted at edge t appears in the statistic outputs after edge t+2.
- Report latency: report pulse at edge t, then DRAIN during t+1 and t+2, then rpt_valid = 1 from edge t+3.
- rpt_valid may be held indefinitely. The snapshot stays unchanged until the handshake completes.
- Throughput: one sample per cycle in RUN.

## Structure
- Package approx_mon_pkg holds:
  - The FSM state enum (RUN, DRAIN, REPORT).
  - DRAIN_CYCLES = 2.
  - A saturating-increment function.
- One sub-module, approx_err_stage, holds the stage-2 datapath: ED computation, the two flags, and the saturating accumulators. The FSM and stage 1 live in the top level.

## Test plan
- Exact sample: X=0x0001, Y=0x0001, S=0x0002, Co=0, then report → n_samples=1, n_err=0, sum_ed=0, max_ed=0, with rpt_valid at cycle +3.
- Single error: X=0xFFFF, Y=0xFFFF, S=0xFFFF, Co=1 (exact 0x1FFFE) → n_err=1, n_hi_err=0, sum_ed=1, max_ed=1.
- High-part error: X=0x00FF, Y=0x00FF, S=0x017E, Co=0 (exact 0x01FE) → ED=0x80, n_hi_err=1, max_ed=0x80.
- Back-to-back stream of 5 samples with report on the cycle of the last one → n_samples=5. in_ready is low for exactly the 2 DRAIN cycles plus the REPORT cycles, and rpt_ready held low for 4 cycles keeps the snapshot stable.
- clear coincident with a valid erroneous sample (ED=3) after prior history → n_samples=1, sum_ed=3. A clear issued during REPORT is ignored.
- Saturation (force CNT_W=4): 20 erroneous samples → n_err=15 and no wrap. rst mid-REPORT → rpt_valid=0 and all statistics 0 on the next cycle.
